multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the single-issue MIPS-subset core: LW SW J JAL BEQ BNE XORI ADDI, R-type, JR.

---
 rtl/mips_defs_pkg.sv | 81 ++++++++
 rtl/multicycle_perf_cnt.sv | 32 +++
 rtl/multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, funct codes,
// ALU operations, datapath mux selects and FSM state encoding.
package mips_defs_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_SLT = 3'd3,
        ALU_AND = 3'd4,
        ALU_OR  = 3'd5,
        ALU_NOP = 3'd7
    } aluOpT;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pcSrcT;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } regDstT;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_DATA = 2'd1,
        WB_LINK = 2'd2
    } wbSelT;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } stateT;

    // ALU_NOP doubles as the "unsupported funct" marker.
    function automatic aluOpT functToAlu(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_XOR:  return ALU_XOR;
            FN_SLT:  return ALU_SLT;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_perf_cnt.sv
// Cycle, retired-instruction and taken-branch counters for multicycle_ctrl.
// Present only in builds with MULTICYCLE_PERF_CNT_EN defined.
module multicycle_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instrDone,
    input  logic             brTaken,
    output logic [CNT_W-1:0] cycCnt,
    output logic [CNT_W-1:0] instrCnt,
    output logic [CNT_W-1:0] brTakenCnt
);

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycCnt     <= '0;
            instrCnt   <= '0;
            brTakenCnt <= '0;
        end else begin
            cycCnt <= cycCnt + CNT_W'(1);
            if (instrDone) begin
                instrCnt <= instrCnt + CNT_W'(1);
            end
            if (brTaken) begin
                brTakenCnt <= brTakenCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset core (fetch/decode/execute/mem/writeback).
// Define MULTICYCLE_PERF_CNT_EN to add the cyc_cnt/instr_cnt/br_taken_cnt counter outputs.
//
// state      | meaning
// FETCH      | read instruction; load IR and PC+4 on mem_ready
// DECODE     | classify opcode/funct
// EXEC_R     | R-type ALU op from funct
// WB_R       | write rd with ALU result
// EXEC_I     | ADDI/XORI with immediate operand
// WB_I       | write rt with ALU result
// MEM_ADDR   | base + imm address for LW/SW
// MEM_RD     | load, held until mem_ready
// WB_MEM     | write rt with load data
// MEM_WR     | store, held until mem_ready
// BRANCH     | BEQ/BNE resolve from a_eq_b
// JUMP       | J/JAL/JR; JAL links $31
// TRAP       | illegal instruction or memory timeout; absorbing until reset
module multicycle_ctrl
    import mips_defs_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             a_eq_b,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             ir_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             alu_src_b,
    output logic [2:0]       alu_op,
    output logic             instr_done,
    output logic             trap
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] br_taken_cnt
`endif
);

    if (CNT_W < 1 || MEM_WAIT_MAX < 0) begin : gBadParams
        $error("multicycle_ctrl: CNT_W must be >= 1 and MEM_WAIT_MAX >= 0");
    end

    localparam int WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

    stateT             state;
    logic [WAIT_W-1:0] waitCnt;
    logic              waitLast;
    logic              brTake;

    // The stall on which the counter would reach MEM_WAIT_MAX traps unless mem_ready rescues it.
    assign waitLast = (MEM_WAIT_MAX > 0) && (waitCnt == WAIT_LAST);
    assign brTake   = (opcode == OP_BEQ) ? a_eq_b : !a_eq_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            waitCnt <= '0;
        end else begin
            waitCnt <= '0;
            case (state)
                S_FETCH: begin
                    if (mem_ready)     state <= S_DECODE;
                    else if (waitLast) state <= S_TRAP;
                    else               waitCnt <= waitCnt + WAIT_W'(1);
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:         state <= (funct == FN_JR) ? S_JUMP : S_EXEC_R;
                        OP_ADDI, OP_XORI: state <= S_EXEC_I;
                        OP_LW, OP_SW:     state <= S_MEM_ADDR;
                        OP_BEQ, OP_BNE:   state <= S_BRANCH;
                        OP_J, OP_JAL:     state <= S_JUMP;
                        default:          state <= S_TRAP;
                    endcase
                end
                S_EXEC_R:   state <= (functToAlu(funct) == ALU_NOP) ? S_TRAP : S_WB_R;
                S_EXEC_I:   state <= S_WB_I;
                S_MEM_ADDR: state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (mem_ready)     state <= S_WB_MEM;
                    else if (waitLast) state <= S_TRAP;
                    else               waitCnt <= waitCnt + WAIT_W'(1);
                end
                S_MEM_WR: begin
                    if (mem_ready)     state <= S_FETCH;
                    else if (waitLast) state <= S_TRAP;
                    else               waitCnt <= waitCnt + WAIT_W'(1);
                end
                S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state <= S_FETCH;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_TRAP;
            endcase
        end
    end

    // Outputs follow the state register; reset forces the idle pattern immediately.
    always_comb begin
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        ir_we      = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = DST_RT;
        wb_sel     = WB_ALU;
        alu_src_b  = 1'b0;
        alu_op     = ALU_NOP;
        instr_done = 1'b0;
        trap       = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_re = 1'b1;
                    ir_we  = mem_ready;
                    pc_we  = mem_ready;
                end
                S_EXEC_R: alu_op = functToAlu(funct);
                S_WB_R: begin
                    reg_we     = 1'b1;
                    reg_dst    = DST_RD;
                    instr_done = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_b = 1'b1;
                    alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                end
                S_WB_I: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_b = 1'b1;
                    alu_op    = ALU_ADD;
                end
                S_MEM_RD: mem_re = 1'b1;
                S_WB_MEM: begin
                    reg_we     = 1'b1;
                    wb_sel     = WB_DATA;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_we     = 1'b1;
                    instr_done = mem_ready;
                end
                S_BRANCH: begin
                    alu_op     = ALU_SUB;
                    pc_src     = PC_BRANCH;
                    pc_we      = brTake;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_we      = 1'b1;
                    pc_src     = (opcode == OP_RTYPE) ? PC_REG : PC_JUMP;
                    instr_done = 1'b1;
                    if (opcode == OP_JAL) begin
                        reg_we  = 1'b1;
                        reg_dst = DST_RA;
                        wb_sel  = WB_LINK;
                    end
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    logic brTaken;
    assign brTaken = !reset && (state == S_BRANCH) && brTake;

    multicycle_perf_cnt #(.CNT_W(CNT_W)) uPerfCnt (
        .clk        (clk),
        .reset      (reset),
        .instrDone  (instr_done),
        .brTaken    (brTaken),
        .cycCnt     (cyc_cnt),
        .instrCnt   (instr_cnt),
        .brTakenCnt (br_taken_cnt)
    );
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; expected output patterns are hand-computed
// per cycle (c1 = first FETCH cycle after reset release).
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_XORI = 6'b001110, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BAD = 6'b111111;
    localparam logic [5:0] FN_JR = 6'b001000, FN_SUB = 6'b100010, FN_SLT = 6'b101010;
    localparam logic [5:0] FN_BAD = 6'b111111;

    logic clk = 1'b0;
    logic reset, a_eq_b, mem_ready;
    logic [5:0] opcode, funct;
    logic pc_we, ir_we, mem_re, mem_we, reg_we, alu_src_b, instr_done, trap;
    logic [1:0] pc_src, reg_dst, wb_sel;
    logic [2:0] alu_op;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cyc_cnt, instr_cnt, br_taken_cnt;
`endif

    int cmps = 0;
    int errs = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32), .MEM_WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .a_eq_b(a_eq_b),
        .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
        .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we), .reg_dst(reg_dst),
        .wb_sel(wb_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .instr_done(instr_done), .trap(trap)
`ifdef MULTICYCLE_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt), .br_taken_cnt(br_taken_cnt)
`endif
    );

    logic [16:0] obs;
    assign obs = {pc_we, pc_src, ir_we, mem_re, mem_we, reg_we, reg_dst, wb_sel,
                  alu_src_b, alu_op, instr_done, trap};

    function automatic logic [16:0] mk(input int pcWe, input int pcSrc, input int irWe,
                                       input int memRe, input int memWe, input int regWe,
                                       input int regDst, input int wbSel, input int aluSrcB,
                                       input int aluOp, input int done, input int trp);
        return {1'(pcWe), 2'(pcSrc), 1'(irWe), 1'(memRe), 1'(memWe), 1'(regWe),
                2'(regDst), 2'(wbSel), 1'(aluSrcB), 3'(aluOp), 1'(done), 1'(trp)};
    endfunction

    logic [16:0] eIdle, eFetchWait, eFetchGo, eTrap, eAddr;

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = OP_ADDI;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        cmps++;
        if (obs !== eIdle) begin errs++; $display("FAIL reset_outputs got=%h exp=%h", obs, eIdle); end
`ifdef MULTICYCLE_PERF_CNT_EN
        cmps++;
        if ({cyc_cnt, instr_cnt, br_taken_cnt} !== 96'd0)
            begin errs++; $display("FAIL reset_perf got=%h/%h/%h exp=0/0/0", cyc_cnt, instr_cnt, br_taken_cnt); end
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0);
        cmps++;
        if (obs !== eFetchWait) begin errs++; $display("FAIL reset_fetch_wait got=%h exp=%h", obs, eFetchWait); end
        step(1'b1);
        cmps++;
        if (obs !== eFetchGo) begin errs++; $display("FAIL reset_fetch_go got=%h exp=%h", obs, eFetchGo); end
    endtask

    task automatic test_itype();
        logic [5:0] ops [2] = '{OP_ADDI, OP_XORI};
        logic [16:0] want [5];
        for (int t = 0; t < 2; t++) begin
            doReset();
            opcode = ops[t];
            funct = 6'b000000;
            want = '{eFetchGo, eIdle, mk(0,0,0,0,0,0,0,0,1,(t == 0) ? 0 : 2,0,0),
                     mk(0,0,0,0,0,1,0,0,0,7,1,0), eFetchWait};
            for (int c = 0; c < 5; c++) begin
                step(c < 4);
                cmps++;
                if (obs !== want[c]) begin errs++; $display("FAIL itype op=%b c%0d got=%h exp=%h", ops[t], c + 1, obs, want[c]); end
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns [2] = '{FN_SUB, FN_SLT};
        logic [16:0] want [5];
        for (int t = 0; t < 2; t++) begin
            doReset();
            opcode = OP_RTYPE;
            funct = fns[t];
            want = '{eFetchGo, eIdle, mk(0,0,0,0,0,0,0,0,0,(t == 0) ? 1 : 3,0,0),
                     mk(0,0,0,0,0,1,1,0,0,7,1,0), eFetchWait};
            for (int c = 0; c < 5; c++) begin
                step(c < 4);
                cmps++;
                if (obs !== want[c]) begin errs++; $display("FAIL rtype fn=%b c%0d got=%h exp=%h", fns[t], c + 1, obs, want[c]); end
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        logic [3:0] eqs = 4'b0101;   // index 0..3: 1,0,1,0
        logic [3:0] takes = 4'b1001; // index 0..3: 1,0,0,1
        logic [16:0] want [4];
        for (int t = 0; t < 4; t++) begin
            doReset();
            opcode = ops[t];
            funct = 6'b000000;
            a_eq_b = eqs[t];
            want = '{eFetchGo, eIdle, mk(takes[t],1,0,0,0,0,0,0,0,1,1,0), eFetchWait};
            for (int c = 0; c < 4; c++) begin
                step(c < 3);
                cmps++;
                if (obs !== want[c]) begin errs++; $display("FAIL branch op=%b eq=%b c%0d got=%h exp=%h", ops[t], eqs[t], c + 1, obs, want[c]); end
            end
        end
    endtask

    task automatic test_jump();
        logic [5:0] ops [3] = '{OP_J, OP_JAL, OP_RTYPE};
        logic [16:0] c3 [3];
        logic [16:0] want [4];
        c3 = '{mk(1,2,0,0,0,0,0,0,0,7,1,0), mk(1,2,0,0,0,1,2,2,0,7,1,0), mk(1,3,0,0,0,0,0,0,0,7,1,0)};
        for (int t = 0; t < 3; t++) begin
            doReset();
            opcode = ops[t];
            funct = FN_JR;
            want = '{eFetchGo, eIdle, c3[t], eFetchWait};
            for (int c = 0; c < 4; c++) begin
                step(c < 3);
                cmps++;
                if (obs !== want[c]) begin errs++; $display("FAIL jump op=%b c%0d got=%h exp=%h", ops[t], c + 1, obs, want[c]); end
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [8:0] rdy = 9'b011000111; // bit c-1 = mem_ready in cycle c
        logic [16:0] want [9];
        int doneSeen = 0;
        want = '{eFetchGo, eIdle, eAddr, eFetchWait, eFetchWait, eFetchWait, eFetchWait,
                 mk(0,0,0,0,0,1,0,1,0,7,1,0), eFetchWait};
        doReset();
        opcode = OP_LW;
        funct = 6'b000000;
        for (int c = 0; c < 9; c++) begin
            step(rdy[c]);
            if (instr_done === 1'b1) doneSeen++;
            cmps++;
            if (obs !== want[c]) begin errs++; $display("FAIL lw_wait c%0d got=%h exp=%h", c + 1, obs, want[c]); end
        end
        cmps++;
        if (doneSeen !== 1) begin errs++; $display("FAIL lw_done_count got=%0d exp=1", doneSeen); end
    endtask

    task automatic test_sw();
        logic [5:0] rdy = 6'b010111;
        logic [16:0] want [6];
        want = '{eFetchGo, eIdle, eAddr, mk(0,0,0,0,1,0,0,0,0,7,0,0),
                 mk(0,0,0,0,1,0,0,0,0,7,1,0), eFetchWait};
        doReset();
        opcode = OP_SW;
        for (int c = 0; c < 6; c++) begin
            step(rdy[c]);
            cmps++;
            if (obs !== want[c]) begin errs++; $display("FAIL sw c%0d got=%h exp=%h", c + 1, obs, want[c]); end
        end
    endtask

    task automatic test_reset_mid_lw();
        logic [16:0] want [4];
        want = '{eFetchGo, eIdle, eAddr, eFetchWait};
        doReset();
        opcode = OP_LW;
        for (int c = 0; c < 4; c++) begin
            step(c < 3);
            cmps++;
            if (obs !== want[c]) begin errs++; $display("FAIL rst_lw_pre c%0d got=%h exp=%h", c + 1, obs, want[c]); end
        end
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        cmps++;
        if (obs !== eIdle) begin errs++; $display("FAIL rst_lw_held got=%h exp=%h", obs, eIdle); end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0);
            cmps++;
            if (obs !== eFetchWait) begin errs++; $display("FAIL rst_lw_after c%0d got=%h exp=%h", c + 1, obs, eFetchWait); end
        end
        step(1'b1);
        cmps++;
        if (obs !== eFetchGo) begin errs++; $display("FAIL rst_lw_refetch got=%h exp=%h", obs, eFetchGo); end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2] = '{OP_BAD, OP_RTYPE};
        logic [16:0] want [5];
        for (int t = 0; t < 2; t++) begin
            doReset();
            opcode = ops[t];
            funct = FN_BAD;
            if (t == 0) want = '{eFetchGo, eIdle, eTrap, eTrap, eTrap};
            else        want = '{eFetchGo, eIdle, eIdle, eTrap, eTrap};
            for (int c = 0; c < 5; c++) begin
                step(1'b1);
                cmps++;
                if (obs !== want[c]) begin errs++; $display("FAIL illegal op=%b c%0d got=%h exp=%h", ops[t], c + 1, obs, want[c]); end
            end
        end
    endtask

    task automatic test_timeout();
        logic [16:0] memWr;
        memWr = mk(0,0,0,0,1,0,0,0,0,7,0,0);
        // 15 low cycles in FETCH -> trapped; late mem_ready is ignored
        doReset();
        opcode = OP_ADDI;
        for (int c = 0; c < 15; c++) begin
            step(1'b0);
            cmps++;
            if (obs !== eFetchWait) begin errs++; $display("FAIL tmo_fetch c%0d got=%h exp=%h", c + 1, obs, eFetchWait); end
        end
        step(1'b1);
        cmps++;
        if (obs !== eTrap) begin errs++; $display("FAIL tmo_fetch_trap got=%h exp=%h", obs, eTrap); end
        // 14 low cycles then ready on the 15th completes normally
        doReset();
        for (int c = 0; c < 14; c++) step(1'b0);
        step(1'b1);
        cmps++;
        if (obs !== eFetchGo) begin errs++; $display("FAIL tmo_edge_go got=%h exp=%h", obs, eFetchGo); end
        step(1'b0);
        cmps++;
        if (obs !== eIdle) begin errs++; $display("FAIL tmo_edge_decode got=%h exp=%h", obs, eIdle); end
        // store that never completes
        doReset();
        opcode = OP_SW;
        for (int c = 0; c < 3; c++) step(1'b1);
        for (int c = 0; c < 15; c++) begin
            step(1'b0);
            cmps++;
            if (obs !== memWr) begin errs++; $display("FAIL tmo_sw c%0d got=%h exp=%h", c + 4, obs, memWr); end
        end
        step(1'b1);
        cmps++;
        if (obs !== eTrap) begin errs++; $display("FAIL tmo_sw_trap got=%h exp=%h", obs, eTrap); end
    endtask

`ifdef MULTICYCLE_PERF_CNT_EN
    task automatic test_perf();
        doReset();
        opcode = OP_ADDI;
        a_eq_b = 1'b1;
        for (int c = 0; c < 4; c++) step(1'b1);
        opcode = OP_BEQ;
        for (int c = 0; c < 3; c++) step(1'b1);
        step(1'b0);
        cmps++;
        if (cyc_cnt !== 32'd7) begin errs++; $display("FAIL perf_cyc got=%0d exp=7", cyc_cnt); end
        cmps++;
        if (instr_cnt !== 32'd2) begin errs++; $display("FAIL perf_instr got=%0d exp=2", instr_cnt); end
        cmps++;
        if (br_taken_cnt !== 32'd1) begin errs++; $display("FAIL perf_br got=%0d exp=1", br_taken_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        opcode = 6'b000000;
        funct = 6'b000000;
        a_eq_b = 1'b0;
        mem_ready = 1'b0;
        eIdle      = mk(0,0,0,0,0,0,0,0,0,7,0,0);
        eFetchWait = mk(0,0,0,1,0,0,0,0,0,7,0,0);
        eFetchGo   = mk(1,0,1,1,0,0,0,0,0,7,0,0);
        eTrap      = mk(0,0,0,0,0,0,0,0,0,7,0,1);
        eAddr      = mk(0,0,0,0,0,0,0,0,1,0,0,0);
        test_reset();
        test_itype();
        test_rtype();
        test_branch();
        test_jump();
        test_lw_wait();
        test_sw();
        test_reset_mid_lw();
        test_illegal();
        test_timeout();
`ifdef MULTICYCLE_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
